// File: rtl/ram_pkg.sv
// ----------------------------------------------------------------------------
// Package: ram_pkg
//
// Purpose
//   Shared constants and the word type for the single-port RAM.
//   Blocks that exchange RAM words import this package, so they all
//   agree on the same geometry.
//
// Contents
//   RAM_DATA_W   default data width (bits per word)
//   RAM_ADDR_W   default address width (the depth is 2**RAM_ADDR_W)
//   ram_word_t   one RAM word at the default data width
// ----------------------------------------------------------------------------
package ram_pkg;

    localparam int RAM_DATA_W = 8;
    localparam int RAM_ADDR_W = 8;

    typedef logic [RAM_DATA_W-1:0] ram_word_t;

endpackage : ram_pkg

// File: rtl/single_port_ram.sv
// ----------------------------------------------------------------------------
// Module: single_port_ram
//
// Purpose
//   Synchronous single-port RAM. Reads and writes share one address bus.
//   The read data is registered, so q is valid one clock after the address
//   is sampled. A write also passes its data through to q on the same edge
//   (write-through). The structure fits block-RAM inference with an output
//   register: no combinational path reaches q.
//
// Parameters
//   DATA_WIDTH   width of data and q
//   ADDR_WIDTH   width of address
//   DEPTH        number of words (addresses 0..DEPTH-1)
//
// Ports
//   clk       in   1            rising-edge clock
//   rst_n     in   1            asynchronous active-low reset (clears q only)
//   data      in   DATA_WIDTH   write data
//   address   in   ADDR_WIDTH   word address, shared by read and write
//   wr        in   1            1 = write cycle, 0 = read cycle
//   q         out  DATA_WIDTH   registered read data
// ----------------------------------------------------------------------------
module single_port_ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_W,
    parameter int ADDR_WIDTH = RAM_ADDR_W,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  wr,
    output logic [DATA_WIDTH-1:0] q
);

    // Storage array. Reset does not clear it, so its contents survive reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port. Writes are gated by rst_n rather than reset by it. A write
    // whose edge falls while reset is asserted is dropped. The array keeps
    // no reset term, so it can still map onto block RAM.
    always_ff @(posedge clk) begin
        if (rst_n && wr) begin
            mem[address] <= data;
        end
    end

    // Output register. On a write, q takes the incoming data (write-through).
    // On a read, q takes the word stored before this edge. The asynchronous
    // reset forces q to zero at once and holds it there while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (wr) begin
            q <= data;
        end else begin
            q <= mem[address];
        end
    end

endmodule : single_port_ram

// File: tb/tb_single_port_ram.sv
// ----------------------------------------------------------------------------
// Testbench: tb_single_port_ram
//
// Directed vectors with hand-computed expected values for single_port_ram.
// Inputs change on the falling edge. q is sampled 1 ns after the rising
// edge that performs the operation.
// ----------------------------------------------------------------------------
module tb_single_port_ram;

    import ram_pkg::*;

    logic      clk;
    logic      rst_n;
    ram_word_t data;
    logic [RAM_ADDR_W-1:0] address;
    logic      wr;
    ram_word_t q;

    int checkCount;
    int failCount;

    single_port_ram #(
        .DATA_WIDTH (RAM_DATA_W),
        .ADDR_WIDTH (RAM_ADDR_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .address (address),
        .wr      (wr),
        .q       (q)
    );

    // 10 ns clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one observed value against the value computed by hand.
    // The comparison uses !== so that an X on q counts as a failure.
    task automatic checkOutput(input string tag, input ram_word_t observed,
                               input ram_word_t expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one operation on the falling edge, then lets it take effect on
    // the next rising edge. The task returns 1 ns after that edge, when q
    // reflects the operation.
    task automatic applyStimulus(input logic isWrite, input logic [RAM_ADDR_W-1:0] addr,
                                 input ram_word_t wdata);
        @(negedge clk);
        wr      = isWrite;
        address = addr;
        data    = wdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        wr         = 1'b0;
        address    = '0;
        data       = '0;
        rst_n      = 1'b0;
        #12;
        checkOutput("initial_reset_q", q, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Load q with FF, then assert reset between edges. q must clear
        // without a clock edge.
        applyStimulus(1'b1, 8'd200, 8'hFF);
        checkOutput("preload_ff", q, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_q", q, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("reset_hold_%0d", i), q, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Consecutive writes: q follows each written word (write-through).
        applyStimulus(1'b1, 8'd70, 8'h4A);
        checkOutput("wr_70", q, 8'h4A);
        applyStimulus(1'b1, 8'd64, 8'hC0);
        checkOutput("wr_64", q, 8'hC0);
        applyStimulus(1'b1, 8'd127, 8'h6F);
        checkOutput("wr_127", q, 8'h6F);

        // Consecutive reads in a different order.
        applyStimulus(1'b0, 8'd64, 8'h00);
        checkOutput("rd_64", q, 8'hC0);
        applyStimulus(1'b0, 8'd70, 8'h00);
        checkOutput("rd_70", q, 8'h4A);
        applyStimulus(1'b0, 8'd127, 8'h00);
        checkOutput("rd_127", q, 8'h6F);

        // The word written before reset must survive reset.
        applyStimulus(1'b0, 8'd200, 8'h00);
        checkOutput("rd_200_survives_reset", q, 8'hFF);

        // Read-after-write on the next edge.
        applyStimulus(1'b1, 8'd0, 8'h55);
        checkOutput("wr_0", q, 8'h55);
        applyStimulus(1'b0, 8'd0, 8'h00);
        checkOutput("raw_0", q, 8'h55);

        // Boundary addresses: no aliasing between 0 and 255.
        applyStimulus(1'b1, 8'd255, 8'hA5);
        checkOutput("wr_255", q, 8'hA5);
        applyStimulus(1'b1, 8'd0, 8'h5A);
        checkOutput("wr_0_b", q, 8'h5A);
        applyStimulus(1'b0, 8'd255, 8'h00);
        checkOutput("rd_255", q, 8'hA5);
        applyStimulus(1'b0, 8'd0, 8'h00);
        checkOutput("rd_0", q, 8'h5A);

        // Changing the inputs without a clock edge must leave q unchanged.
        @(negedge clk);
        wr      = 1'b1;
        address = 8'd64;
        data    = 8'h99;
        #2;
        checkOutput("no_edge_stable", q, 8'h5A);
        wr = 1'b0;

        // Mid-operation reset: a write during reset must be discarded.
        applyStimulus(1'b1, 8'd10, 8'h11);
        checkOutput("wr_10", q, 8'h11);
        @(negedge clk);
        wr      = 1'b1;
        address = 8'd10;
        data    = 8'h22;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midop_reset_q", q, 8'h00);
        @(negedge clk);
        wr    = 1'b0;
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'd10, 8'h00);
        checkOutput("rd_10_after_reset", q, 8'h11);

        // The 64 location must not have been hit by the edge-less input change.
        applyStimulus(1'b0, 8'd64, 8'h00);
        checkOutput("rd_64_untouched", q, 8'hC0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule : tb_single_port_ram
